// File: rtl/program_loader.sv
// program_loader: packs a host byte stream into 16-bit words for instruction memory and holds the CPU in reset while loading.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module program_loader #(
  parameter int ADDR_W  = 7,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [7:0]        In_Data,
  input  logic              In_Valid,
  output logic              In_Ready,
  output logic [ADDR_W-1:0] IM_Addr,
  output logic [15:0]       IM_Data,
  output logic              IM_Wr,
  output logic              CPU_Hold,
  output logic              Busy,
  output logic              Done,
  output logic              Error,
  output logic [7:0]        Words_Loaded
);
  localparam logic [8:0] MAX_WORDS = 9'(2**ADDR_W);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_HI, S_LO, S_WRITE, S_CSUM, S_DONE, S_ERR} state_t;
`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_FINAL = S_CSUM;
  logic [7:0] csum_q;
`else
  localparam state_t S_FINAL = S_DONE;
`endif
  state_t          state_q, state_d;
  logic [7:0]      n_q, hi_q, words_q;
  logic [TW-1:0]   idle_q;
  logic            xfer, last, idle_st, timed_out;
  assign xfer      = In_Valid && In_Ready;
  assign idle_st   = state_q inside {S_IDLE, S_DONE, S_ERR};
  assign last      = words_q + 8'd1 == n_q;
  assign timed_out = In_Ready && !xfer && idle_q == TW'(TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      idle_q  <= '0;
      n_q     <= '0;
      hi_q    <= '0;
      words_q <= '0;
      IM_Addr <= '0;
      IM_Data <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idle_q  <= (xfer || !In_Ready) ? '0 : idle_q + 1'b1;
      if (idle_st && Start) words_q <= '0;
      else if (IM_Wr) words_q <= words_q + 8'd1;
      if (xfer && state_q == S_LEN) n_q <= In_Data;
      if (xfer && state_q == S_HI) hi_q <= In_Data;
      if (xfer && state_q == S_LO) begin
        IM_Addr <= words_q[ADDR_W-1:0];
        IM_Data <= {hi_q, In_Data};
      end
`ifdef LOADER_CHECKSUM_EN
      if (idle_st && Start) csum_q <= '0;
      else if (xfer) csum_q <= csum_q ^ In_Data;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: state_d = Start ? S_LEN : state_q;
      S_LEN:   if (xfer) state_d = (In_Data == 8'd0 || {1'b0, In_Data} > MAX_WORDS) ? S_ERR : S_HI;
      S_HI:    if (xfer) state_d = S_LO;
      S_LO:    if (xfer) state_d = S_WRITE;
      S_WRITE: state_d = last ? S_FINAL : S_HI;
`ifdef LOADER_CHECKSUM_EN
      S_CSUM:  if (xfer) state_d = (csum_q == In_Data) ? S_DONE : S_ERR;
`endif
      default: state_d = S_IDLE;
    endcase
    if (timed_out) state_d = S_ERR;
  end
  always_comb begin
    In_Ready     = state_q inside {S_LEN, S_HI, S_LO, S_CSUM};
    IM_Wr        = state_q == S_WRITE;
    Busy         = In_Ready || IM_Wr;
    CPU_Hold     = Busy || state_q == S_ERR;
    Done         = state_q == S_DONE;
    Error        = state_q == S_ERR;
    Words_Loaded = words_q;
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: random and directed streams against a byte-position reference model of the loader.
`timescale 1ns/1ps
module tb_program_loader;
  localparam int ADDR_W = 7, TIMEOUT = 1024, MAXW = 128;
  logic clk = 0, Reset = 1, Start = 0, In_Valid = 0;
  logic [7:0] In_Data = 0;
  logic In_Ready, IM_Wr, CPU_Hold, Busy, Done, Error;
  logic [ADDR_W-1:0] IM_Addr;
  logic [15:0] IM_Data;
  logic [7:0] Words_Loaded;
  int checks = 0, errors = 0;
  program_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .Reset(Reset), .Start(Start), .In_Data(In_Data), .In_Valid(In_Valid),
    .In_Ready(In_Ready), .IM_Addr(IM_Addr), .IM_Data(IM_Data), .IM_Wr(IM_Wr),
    .CPU_Hold(CPU_Hold), .Busy(Busy), .Done(Done), .Error(Error), .Words_Loaded(Words_Loaded));
  always #5 clk = ~clk;
  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  // Reference: status 0 idle, 1 loading, 2 done, 3 error; pos = index of next stream byte.
  int m_st = 0, m_pos = 0, m_n = 0, m_idle = 0, m_words = 0;
  bit m_wp = 0, m_on = 0;
  logic [7:0] m_hi = 0, m_cs = 0;
  logic [ADDR_W-1:0] m_addr = 0;
  logic [15:0] m_data = 0;
  always @(posedge clk) begin
    if (Reset) begin
      m_st = 0; m_pos = 0; m_n = 0; m_idle = 0; m_words = 0; m_wp = 0;
      m_addr = 0; m_data = 0; m_on = 1;
    end else if (m_st != 1) begin
      if (Start) begin m_st = 1; m_pos = 0; m_words = 0; m_idle = 0; m_cs = 0; end
    end else if (m_wp) begin
      m_wp = 0;
      m_words++;
`ifndef LOADER_CHECKSUM_EN
      if (m_words == m_n) m_st = 2;
`endif
    end else if (In_Valid) begin
      m_idle = 0;
      if (m_pos == 0) begin
        m_n = int'(In_Data);
        if (m_n == 0 || m_n > MAXW) m_st = 3;
      end else if (m_pos <= 2 * m_n) begin
        if (m_pos % 2 == 1) m_hi = In_Data;
        else begin m_addr = ADDR_W'(m_words); m_data = {m_hi, In_Data}; m_wp = 1; end
      end else m_st = (In_Data == m_cs) ? 2 : 3;
      m_cs ^= In_Data;
      m_pos++;
    end else begin
      m_idle++;
      if (m_idle == TIMEOUT) m_st = 3;
    end
  end
  always @(negedge clk) begin
    logic [36:0] got, exp;
    if (m_on) begin
      got = {In_Ready, IM_Addr, IM_Data, IM_Wr, CPU_Hold, Busy, Done, Error, Words_Loaded};
      exp = {m_st == 1 && !m_wp, m_addr, m_data, m_wp, m_st == 1 || m_st == 3, m_st == 1,
             m_st == 2, m_st == 3, 8'(m_words)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL cycle_compare t=%0t got rdy/addr/data/wr/hold/busy/done/err/words=%h required %h",
                 $time, got, exp);
      end
    end
  end
  logic [22:0] wlog[$];
  always @(posedge clk) if (IM_Wr) wlog.push_back({IM_Addr, IM_Data});
  logic [7:0] strm[$];
  logic [15:0] img[$];
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h required %h", nm, got, exp);
    end
  endtask
  task automatic pack(input int n);
    logic [7:0] cs;
    strm.delete();
    strm.push_back(8'(n));
    cs = 8'(n);
    if (n >= 1 && n <= MAXW) begin
      foreach (img[i]) begin
        strm.push_back(img[i][15:8]);
        strm.push_back(img[i][7:0]);
        cs ^= img[i][15:8] ^ img[i][7:0];
      end
`ifdef LOADER_CHECKSUM_EN
      strm.push_back(cs);
`endif
    end
  endtask
  task automatic rand_img(input int n);
    img.delete();
    if (n >= 1 && n <= MAXW) for (int i = 0; i < n; i++) img.push_back(16'($urandom));
    pack(n);
  endtask
  task automatic chk_image(input string nm);
    int bad = 0;
    if (wlog.size() != img.size()) bad++;
    else foreach (img[i]) if (wlog[i] !== {ADDR_W'(i), img[i]}) bad++;
    chk(nm, bad, 0);
  endtask
  task automatic start_load();
    Start = 1;
    @(posedge clk); #1;
    Start = 0;
  endtask
  task automatic send_byte(input logic [7:0] b, input int gmin, input int gmax, input bit noisy);
    int k = 0;
    bit r;
    In_Valid = 0;
    repeat ($urandom_range(gmax, gmin)) begin
      In_Data = 8'($urandom);
      Start = noisy && $urandom_range(3, 0) == 0;
      @(posedge clk); #1;
    end
    In_Valid = 1;
    In_Data = b;
    do begin
      @(negedge clk); r = In_Ready;
      @(posedge clk); #1;
      k++;
      Start = noisy && !r && $urandom_range(3, 0) == 0;
    end while (!r && k < 3000);
    Start = 0;
    In_Valid = 0;
    if (!r) begin
      errors++;
      checks++;
      $display("FAIL handshake got no In_Ready required byte %h accepted", b);
    end
  endtask
  task automatic wait_settle();
    int k = 0;
    do begin @(negedge clk); k++; end while (Busy && k < 5000);
    if (Busy) begin
      errors++;
      checks++;
      $display("FAIL settle got Busy=1 required 0");
    end
    @(posedge clk); #1;
  endtask
  task automatic run_load(input int gmin, input int gmax, input bit noisy);
    wlog.delete();
    start_load();
    foreach (strm[i]) send_byte(strm[i], gmin, gmax, noisy);
    wait_settle();
  endtask
  initial begin
    int k, n;
    repeat (3) @(posedge clk);
    #1 Reset = 0;
    chk("reset_busy", Busy, 0);
    chk("reset_hold", CPU_Hold, 0);
    chk("reset_words", Words_Loaded, 0);
    chk("reset_addr", IM_Addr, 0);
    img = '{16'h1234, 16'h5678, 16'h5000};
    pack(3);
    run_load(0, 0, 0);
    chk("full_count", wlog.size(), 3);
    chk("full_w0", wlog[0], {7'h00, 16'h1234});
    chk("full_w1", wlog[1], {7'h01, 16'h5678});
    chk("full_w2", wlog[2], {7'h02, 16'h5000});
    chk("full_done", Done, 1);
    chk("full_hold", CPU_Hold, 0);
    chk("full_words", Words_Loaded, 3);
    chk("full_error", Error, 0);
    run_load(1, 50, 1);
    chk_image("gap_image");
    chk("gap_done", Done, 1);
    foreach (strm[i]) if (i == 0) begin strm = '{8'h00}; end
    run_load(0, 0, 0);
    chk("len00_error", Error, 1);
    chk("len00_done", Done, 0);
    chk("len00_hold", CPU_Hold, 1);
    chk("len00_nowrite", wlog.size(), 0);
    strm = '{8'h81};
    run_load(0, 0, 0);
    chk("len81_error", Error, 1);
    chk("len81_nowrite", wlog.size(), 0);
    wlog.delete();
    start_load();
    send_byte(8'h02, 0, 0, 0);
    send_byte(8'h12, 0, 0, 0);
    send_byte(8'h34, 0, 0, 0);
    send_byte(8'hAB, 0, 0, 0);
    k = 0;
    forever begin
      @(negedge clk);
      if (Error || k > 2 * TIMEOUT) break;
      @(posedge clk); #1;
      k++;
    end
    @(posedge clk); #1;
    chk("timeout_cycles", k, TIMEOUT);
    chk("timeout_error", Error, 1);
    chk("timeout_words", Words_Loaded, 1);
    chk("timeout_hold", CPU_Hold, 1);
    chk("timeout_w0", wlog[0], {7'h00, 16'h1234});
    wlog.delete();
    start_load();
    send_byte(8'h02, 0, 0, 0);
    send_byte(8'h12, 0, 0, 0);
    Start = 1;
    @(posedge clk); #1;
    chk("start_ignored_busy", Busy, 1);
    Reset = 1;
    @(posedge clk); #1;
    Reset = 0;
    Start = 0;
    chk("midreset_busy", Busy, 0);
    chk("midreset_hold", CPU_Hold, 0);
    chk("midreset_words", Words_Loaded, 0);
    repeat (5) @(posedge clk);
    #1 chk("midreset_nowrite", wlog.size(), 0);
    rand_img(MAXW);
    run_load(0, 1, 0);
    chk_image("max_image");
    chk("max_last_addr", wlog[wlog.size() - 1][22:16], 7'h7F);
    chk("max_done", Done, 1);
    for (int t = 0; t < 10; t++) begin
      n = ($urandom_range(5, 0) == 0) ? (($urandom_range(1, 0) == 0) ? 0 : $urandom_range(255, 129))
                                       : $urandom_range(20, 1);
      rand_img(n);
      run_load(0, 3, t % 2 == 1);
      chk_image("rand_image");
      chk("rand_status", {Done, Error}, (n >= 1 && n <= MAXW) ? 2'b10 : 2'b01);
    end
`ifdef LOADER_CHECKSUM_EN
    strm = '{8'h01, 8'h50, 8'h00, 8'h51};
    run_load(0, 0, 0);
    chk("csum_good_done", Done, 1);
    strm = '{8'h01, 8'h50, 8'h00, 8'h50};
    run_load(0, 0, 0);
    chk("csum_bad_error", Error, 1);
    chk("csum_bad_hold", CPU_Hold, 1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
